// File: rtl/channel_mux_arb_pkg.sv
// Shared types and constants for the 8-to-1 channel merge path.
package channel_mux_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_t;

  // Round-robin successor of a granted index; wraps 7 -> 0 by width.
  function automatic sel_t next_ptr(input sel_t gnt);
    return gnt + SEL_W'(1);
  endfunction

endpackage

// File: rtl/channel_mux_arb_if.sv
// Bus bundle for channel_mux_arb.
//   slave  : DUT side (inputs: mode/selector/channel data/valid/out_ready;
//            outputs: ready, out_data, out_sel, out_valid)
//   master : driver side, directions mirrored
interface channel_mux_arb_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  import channel_mux_pkg::*;

  logic                  mode_i;
  sel_t                  selector_i;
  logic [DATA_WIDTH-1:0] channel_a_i;
  logic [DATA_WIDTH-1:0] channel_b_i;
  logic [DATA_WIDTH-1:0] channel_c_i;
  logic [DATA_WIDTH-1:0] channel_d_i;
  logic [DATA_WIDTH-1:0] channel_e_i;
  logic [DATA_WIDTH-1:0] channel_f_i;
  logic [DATA_WIDTH-1:0] channel_g_i;
  logic [DATA_WIDTH-1:0] channel_h_i;
  logic [NUM_CH-1:0]     valid_i;
  logic [NUM_CH-1:0]     ready_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  sel_t                  out_sel_o;
  logic                  out_valid_o;
  logic                  out_ready_i;

  modport slave (
    input  mode_i, selector_i,
    input  channel_a_i, channel_b_i, channel_c_i, channel_d_i,
    input  channel_e_i, channel_f_i, channel_g_i, channel_h_i,
    input  valid_i, out_ready_i,
    output ready_o, out_data_o, out_sel_o, out_valid_o
  );

  modport master (
    output mode_i, selector_i,
    output channel_a_i, channel_b_i, channel_c_i, channel_d_i,
    output channel_e_i, channel_f_i, channel_g_i, channel_h_i,
    output valid_i, out_ready_i,
    input  ready_o, out_data_o, out_sel_o, out_valid_o
  );

endinterface

// File: rtl/channel_mux_arb_rr_arbiter8.sv
// Combinational 8-way priority search starting at ptr, wrapping 7 -> 0.
//   req        : request vector
//   ptr        : highest-priority index
//   gnt_onehot : one-hot grant (zero when no request)
//   gnt_idx    : granted index (0 when no request)
//   gnt_any    : any request present
module rr_arbiter8
  import channel_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic [NUM_CH-1:0] gnt_onehot,
  output sel_t              gnt_idx,
  output logic              gnt_any
);

  sel_t cand;

  // First set bit at or above ptr, modulo 8.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    cand       = ptr;
    gnt_onehot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = ptr + SEL_W'(i);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) begin
      gnt_onehot = NUM_CH'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/channel_mux_arb.sv
// Merges eight valid/ready input channels onto one registered output beat
// tagged with its source index.
//   clk_i  : clock, rising edge
//   arst_i : asynchronous reset, active-high
//   bus    : channel_mux_arb_if.slave (inputs, per-channel ready, output beat)
module channel_mux_arb
  import channel_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             arst_i,
  channel_mux_arb_if.slave bus
);

  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  assign ch_data[0] = bus.channel_a_i;
  assign ch_data[1] = bus.channel_b_i;
  assign ch_data[2] = bus.channel_c_i;
  assign ch_data[3] = bus.channel_d_i;
  assign ch_data[4] = bus.channel_e_i;
  assign ch_data[5] = bus.channel_f_i;
  assign ch_data[6] = bus.channel_g_i;
  assign ch_data[7] = bus.channel_h_i;

  sel_t                  ptr_q;
  logic [DATA_WIDTH-1:0] data_q;
  sel_t                  sel_q;
  logic                  valid_q;

  logic              load;
  logic              fixed_mode;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt_onehot;
  sel_t              gnt_idx;
  logic              gnt_any;

  // Output register may accept a new beat when empty or being drained.
  assign load       = !valid_q || bus.out_ready_i;
  assign fixed_mode = (mode_t'(bus.mode_i) == MODE_FIXED);
  assign req        = fixed_mode ? (bus.valid_i & (NUM_CH'(1) << bus.selector_i))
                                 : bus.valid_i;

  rr_arbiter8 u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // No input is acknowledged while reset is asserted.
  assign bus.ready_o = (load && !arst_i) ? gnt_onehot : '0;

  // Output beat register and round-robin pointer.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      if (gnt_any) begin
        data_q  <= ch_data[gnt_idx];
        sel_q   <= gnt_idx;
        valid_q <= 1'b1;
        if (!fixed_mode) begin
          ptr_q <= next_ptr(gnt_idx);
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data_o  = data_q;
  assign bus.out_sel_o   = sel_q;
  assign bus.out_valid_o = valid_q;

endmodule

// File: tb/tb_channel_mux_arb.sv
// Scoreboard bench for channel_mux_arb: directed stimulus pushes the
// expected {sel, data} of each granted beat; a negedge monitor pops and
// compares on every output transfer and checks ready_o every cycle.
module tb_channel_mux_arb;

  localparam int unsigned DW = 32;

  logic clk_i = 1'b0;
  logic arst_i;

  always #5 clk_i = ~clk_i;

  channel_mux_arb_if #(.DATA_WIDTH(DW)) bus ();

  channel_mux_arb #(.DATA_WIDTH(DW)) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus)
  );

  logic [DW-1:0] ch_data [8];

  assign bus.channel_a_i = ch_data[0];
  assign bus.channel_b_i = ch_data[1];
  assign bus.channel_c_i = ch_data[2];
  assign bus.channel_d_i = ch_data[3];
  assign bus.channel_e_i = ch_data[4];
  assign bus.channel_f_i = ch_data[5];
  assign bus.channel_g_i = ch_data[6];
  assign bus.channel_h_i = ch_data[7];

  int n_cmp = 0;
  int n_err = 0;

  logic [DW+2:0] exp_q [$];
  logic [7:0]    exp_ready = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic m, input logic [2:0] s, input logic [7:0] v,
                       input logic r, input logic [7:0] er);
    bus.mode_i      = m;
    bus.selector_i  = s;
    bus.valid_i     = v;
    bus.out_ready_i = r;
    exp_ready       = er;
  endtask

  task automatic push(input logic [2:0] s, input logic [DW-1:0] d);
    exp_q.push_back({s, d});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: ready_o every cycle, output beats on each transfer.
  always @(negedge clk_i) begin
    logic [DW+2:0] e;
    chk("ready_o", 32'(bus.ready_o), 32'(exp_ready));
    if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got sel %0d data %h, required no beat",
                 bus.out_sel_o, bus.out_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("beat_sel", 32'(bus.out_sel_o), 32'(e[DW+2:DW]));
        chk("beat_data", bus.out_data_o, e[DW-1:0]);
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) ch_data[k] = 32'h1000_0000 + 32'(k);
    arst_i = 1'b1;
    drive(1'b0, 3'd0, 8'hFF, 1'b1, 8'h00);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_out_data", bus.out_data_o, 32'd0);
    chk("rst_out_sel", 32'(bus.out_sel_o), 32'd0);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 8'h00);
    #2 arst_i = 1'b0;
    tick();

    // 1: full round-robin rotation, no bubbles
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 3'd0, 8'hFF, 1'b1, 8'h01 << (i % 8));
      push(3'(i % 8), 32'h1000_0000 + 32'(i % 8));
      tick();
    end

    // 2: fixed mode on channel d
    ch_data[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd3, 8'hFF, 1'b1, 8'h08);
      push(3'd3, 32'hDEAD_BEEF);
      tick();
    end
    ch_data[3] = 32'h1000_0003;

    // 3: backpressure hold on a channel-2 beat
    ch_data[2] = 32'h2222_2222;
    drive(1'b0, 3'd0, 8'h04, 1'b1, 8'h04);
    push(3'd2, 32'h2222_2222);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd0, 8'h04, 1'b0, 8'h00);
      @(negedge clk_i);
      chk("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
      chk("bp_out_data", bus.out_data_o, 32'h2222_2222);
      chk("bp_out_sel", 32'(bus.out_sel_o), 32'd2);
      tick();
    end
    drive(1'b0, 3'd0, 8'h04, 1'b1, 8'h04);
    push(3'd2, 32'h2222_2222);
    tick();

    // 4: sparse RR with wrap; pointer 3 -> 5 via ch4, then 0 wins, pointer -> 1
    drive(1'b0, 3'd0, 8'h10, 1'b1, 8'h10);
    push(3'd4, 32'h1000_0004);
    tick();
    drive(1'b0, 3'd0, 8'h05, 1'b1, 8'h01);
    push(3'd0, 32'h1000_0000);
    tick();
    drive(1'b0, 3'd0, 8'h05, 1'b1, 8'h04);
    push(3'd2, 32'h2222_2222);
    tick();

    // 6: idle drain
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b1, 8'h00);
      if (i > 0) begin
        @(negedge clk_i);
        chk("idle_out_valid", 32'(bus.out_valid_o), 32'd0);
      end
      tick();
    end

    // 5: reset while a channel-6 beat is held
    drive(1'b0, 3'd0, 8'h40, 1'b1, 8'h40);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
    @(negedge clk_i);
    chk("pre_rst_valid", 32'(bus.out_valid_o), 32'd1);
    chk("pre_rst_data", bus.out_data_o, 32'h1000_0006);
    #2;
    drive(1'b0, 3'd0, 8'hFF, 1'b1, 8'h00);
    arst_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("async_rst_data", bus.out_data_o, 32'd0);
    chk("async_rst_sel", 32'(bus.out_sel_o), 32'd0);
    chk("async_rst_ready", 32'(bus.ready_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    #2;
    arst_i = 1'b0;
    drive(1'b0, 3'd0, 8'h01, 1'b1, 8'h01);
    push(3'd0, 32'h1000_0000);
    #1;
    chk("post_rst_ready", 32'(bus.ready_o), 32'h01);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b1, 8'h00);
    tick();
    tick();

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
